// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the bounded-draw LFSR: mode/FSM enums, default
// maximal-length tap masks, and the rejection-sampling mask function.
package lfsr_pkg;

  typedef enum logic {FIBONACCI = 1'b0, GALOIS = 1'b1} lfsr_mode_e;
  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} draw_state_e;

  // Tap masks for next = {state[W-2:0], ^(state & taps)}; bit i = state[i].
  function automatic logic [31:0] default_taps(input int w);
    case (w)
      3:  return 32'h0000_0005;
      4:  return 32'h0000_0009;
      5:  return 32'h0000_0012;
      6:  return 32'h0000_0021;
      7:  return 32'h0000_0041;
      8:  return 32'h0000_008E;
      9:  return 32'h0000_0108;
      10: return 32'h0000_0204;
      11: return 32'h0000_0402;
      12: return 32'h0000_0CA0;
      13: return 32'h0000_1B00;
      14: return 32'h0000_3500;
      15: return 32'h0000_4001;
      16: return 32'h0000_8805;
      17: return 32'h0001_0004;
      18: return 32'h0002_0040;
      19: return 32'h0007_1000;
      20: return 32'h0008_0004;
      21: return 32'h0010_0002;
      22: return 32'h0020_0001;
      23: return 32'h0040_0010;
      24: return 32'h0080_0043;
      25: return 32'h0100_0004;
      26: return 32'h0388_0000;
      27: return 32'h0720_0000;
      28: return 32'h0800_0004;
      29: return 32'h1000_0002;
      30: return 32'h3280_0000;
      31: return 32'h4000_0004;
      32: return 32'hE000_0200;
      default: return 32'h0000_0003;
    endcase
  endfunction

  // Smallest 2^k-1 >= v: smear the top set bit downwards.
  function automatic logic [31:0] range_mask(input logic [31:0] v);
    logic [31:0] m;
    m = v;
    for (int i = 1; i < 32; i++) m = m | (v >> i);
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR step, Fibonacci or Galois form selected at elaboration.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = '1,
  parameter lfsr_mode_e       MODE  = FIBONACCI
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (MODE == GALOIS) begin : g_galois
      assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? TAPS : '0);
    end else begin : g_fib
      assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
    end
  endgenerate

endmodule

// File: rtl/lfsr_rand.sv
// Free-running LFSR with seed load, zero-state recovery and a bounded random
// draw done by rejection sampling against a power-of-two mask.
module lfsr_rand
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             req,
  input  logic [WIDTH-1:0] range_max,
  output logic [WIDTH-1:0] state,
  output logic             busy,
  output logic             rand_valid,
  output logic [WIDTH-1:0] rand_out,
  output logic             lockup
);

  localparam lfsr_mode_e MODE_E = (MODE == 1) ? GALOIS : FIBONACCI;

  draw_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] step_nxt, candidate, range_q, mask_q;
  logic             draw_step, accept;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE_E)) u_step (
    .cur (state),
    .nxt (step_nxt)
  );

  assign busy      = (fsm_q == DRAW);
  // Load and zero recovery pre-empt the step, so no candidate is judged then.
  assign draw_step = busy && !load && (state != '0);
  assign candidate = step_nxt & mask_q;
  assign accept    = draw_step && (candidate <= range_q);

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (req)    fsm_d = DRAW;
      DRAW:    if (accept) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= IDLE;
    else        fsm_q <= fsm_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SEED;
      rand_valid <= 1'b0;
      rand_out   <= '0;
      lockup     <= 1'b0;
      range_q    <= '0;
      mask_q     <= '0;
    end else begin
      rand_valid <= accept;
      lockup     <= 1'b0;
      if (accept) rand_out <= candidate;
      if (fsm_q == IDLE && req) begin
        range_q <= range_max;
        mask_q  <= WIDTH'(range_mask(32'(range_max)));
      end
      if (load) begin
        if (load_value == '0) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state  <= load_value;
        end
      end else if (state == '0) begin
        state  <= SEED;
        lockup <= 1'b1;
      end else if (en || busy) begin
        state  <= step_nxt;
      end
    end
  end

endmodule
